// File: rtl/hamming_pkg.sv
// Shared types and the Hamming SECDED codeword function for the encoder engine.
package hamming_pkg;

    localparam int unsigned MSG_W = 11;
    localparam int unsigned CW_W  = 16;
    localparam int unsigned IDX_W = 7;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StLatch,
        StWrLo,
        StWrHi
    } enc_state_t;

    // Message bits are numbered d[11:1]; codeword bit k holds Hamming position k, bit 0 is p0.
    function automatic logic [CW_W-1:0] hamming_cw(input logic [MSG_W:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = ^d[11:8] ^ d[4] ^ d[3] ^ d[2];
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/hamming_enc_engine_encode.sv
// Combinational SECDED encoder: 11 message bits in, 16-bit codeword out.
module hamming_encode
    import hamming_pkg::*;
(
    input  logic [MSG_W:1]  d,
    output logic [CW_W-1:0] cw
);

    assign cw = hamming_cw(d);

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-mapped SECDED encoder: reads NUM_MSG messages from data memory and writes back
// their 16-bit codewords through a single shared byte port, five cycles per message.
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata
);

    if (NUM_MSG < 1 || NUM_MSG > 127) begin : g_bad_num_msg
        $error("hamming_enc_engine: NUM_MSG must be 1..127");
    end
    if ((longint'(SRC_BASE) + 2 * longint'(NUM_MSG) > (longint'(1) << ADDR_W)) ||
        (longint'(DST_BASE) + 2 * longint'(NUM_MSG) > (longint'(1) << ADDR_W))) begin : g_bad_addr
        $error("hamming_enc_engine: message or codeword region exceeds address space");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

    enc_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        lo_q, lo_d;
    logic [2:0]        hi_q, hi_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wdata_q, wdata_d;

    logic [MSG_W:1]    enc_in;
    logic [CW_W-1:0]   enc_cw;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[7:3];

    // The high byte is still arriving on mem_rdata while in StLatch, so bypass hi_q then.
    assign enc_in = (state_q == StLatch) ? {mem_rdata[2:0], lo_q} : {hi_q, lo_q};

    hamming_encode u_encode (
        .d  (enc_in),
        .cw (enc_cw)
    );

    assign src_addr = ADDR_W'(SRC_BASE) + ADDR_W'({idx_d, 1'b0});
    assign dst_addr = ADDR_W'(DST_BASE) + ADDR_W'({idx_d, 1'b0});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        done_d  = done_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    done_d  = 1'b0;
                    idx_d   = '0;
                    state_d = StRdLo;
                end
            end
            StRdLo: state_d = StRdHi;
            StRdHi: begin
                lo_d    = mem_rdata;
                state_d = StLatch;
            end
            StLatch: begin
                hi_d    = mem_rdata[2:0];
                state_d = StWrLo;
            end
            StWrLo: state_d = StWrHi;
            StWrHi: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRdLo;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        wdata_d = wdata_q;
        case (state_d)
            StRdLo: addr_d = src_addr;
            StRdHi: addr_d = src_addr + ADDR_W'(1);
            StWrLo: begin
                addr_d  = dst_addr;
                wr_en_d = 1'b1;
                wdata_d = enc_cw[7:0];
            end
            StWrHi: begin
                addr_d  = dst_addr + ADDR_W'(1);
                wr_en_d = 1'b1;
                wdata_d = enc_cw[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
        end
    end

    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_wr_en = wr_en_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed bench for hamming_enc_engine against a behavioural byte memory with 1-cycle reads.
module tb_hamming_enc_engine;

    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    logic       clk;
    logic       reset;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    logic [7:0]  mem [256];
    logic [10:0] msgs [N];
    int          wr_count;
    int          oob_count;
    int          num_checks;
    int          num_errors;

    hamming_enc_engine #(
        .NUM_MSG  (N),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .ADDR_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
            if (int'(mem_addr) < DST || int'(mem_addr) >= DST + 2 * N) oob_count <= oob_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent model: codeword bit k is Hamming position k, data fills non-power-of-two slots.
    function automatic logic [15:0] ref_cw(input logic [10:0] m);
        logic [15:0] cw;
        logic        p;
        int          di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = m[di];
                di++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) if (pos[j]) p ^= cw[pos];
            cw[1 << j] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic load_msgs();
        logic [4:0] junk;
        for (int i = 0; i < N; i++) begin
            junk = 5'($urandom);
            mem[SRC + 2 * i]     = msgs[i][7:0];
            mem[SRC + 2 * i + 1] = {junk, msgs[i][10:8]};
        end
        for (int i = DST; i < DST + 2 * N; i++) mem[i] = 8'hA5;
    endtask

    task automatic random_msgs();
        for (int i = 0; i < N; i++) msgs[i] = 11'($urandom);
    endtask

    task automatic start_run();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Returns the number of cycles after the req-sampling edge until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_cws(input string tag);
        logic [15:0] got;
        for (int i = 0; i < N; i++) begin
            got = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            check($sformatf("%s cw%0d", tag, i), 32'(got), 32'(ref_cw(msgs[i])));
        end
    endtask

    initial begin
        int n, w0, o0, first, low_at, second;
        num_checks = 0;
        num_errors = 0;
        wr_count   = 0;
        oob_count  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        req   = 1'b0;
        reset = 1'b1;
        #1;
        check("rst done", 32'(done), 32'h0);
        check("rst wr_en", 32'(mem_wr_en), 32'h0);
        check("rst addr", 32'(mem_addr), 32'h0);
        check("rst wdata", 32'(mem_wdata), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Run 1: directed corner messages plus random ones with junk in high bits.
        random_msgs();
        msgs[0] = 11'h000;
        msgs[1] = 11'h7FF;
        msgs[2] = 11'h001;
        msgs[3] = 11'h400;
        load_msgs();
        w0 = wr_count;
        o0 = oob_count;
        start_run();
        wait_done(n);
        check("run1 latency", 32'(n), 32'd75);
        check("cw 000 lo", 32'(mem[DST]), 32'h00);
        check("cw 000 hi", 32'(mem[DST + 1]), 32'h00);
        check("cw 7FF", 32'({mem[DST + 3], mem[DST + 2]}), 32'hFFFF);
        check("cw 001", 32'({mem[DST + 5], mem[DST + 4]}), 32'h000F);
        check("cw 400", 32'({mem[DST + 7], mem[DST + 6]}), 32'h8117);
        check_cws("run1");
        check("run1 writes", 32'(wr_count - w0), 32'(2 * N));
        check("run1 oob", 32'(oob_count - o0), 32'd0);
        repeat (3) @(negedge clk);
        check("done sticky", 32'(done), 32'h1);

        // Run 2: req pulse mid-run must not disturb timing.
        random_msgs();
        load_msgs();
        start_run();
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            req = (n == 10 || n == 40);
        end
        req = 1'b0;
        check("run2 latency", 32'(n), 32'd75);
        check_cws("run2");

        // Run 3: reset at cycle 20 aborts; next run is clean.
        random_msgs();
        load_msgs();
        start_run();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort wr_en", 32'(mem_wr_en), 32'h0);
        check("abort done", 32'(done), 32'h0);
        check("abort addr", 32'(mem_addr), 32'h0);
        w0 = wr_count;
        repeat (3) @(negedge clk);
        check("abort no writes", 32'(wr_count - w0), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort idle", 32'(wr_count - w0), 32'd0);
        load_msgs();
        w0 = wr_count;
        start_run();
        wait_done(n);
        check("run3 latency", 32'(n), 32'd75);
        check_cws("run3");
        check("run3 writes", 32'(wr_count - w0), 32'(2 * N));

        // Run 4: req held high gives back-to-back runs with a one-cycle done pulse between.
        random_msgs();
        load_msgs();
        w0 = wr_count;
        o0 = oob_count;
        first  = 0;
        low_at = 0;
        second = 0;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        n = 0;
        while (second == 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (first == 0) begin
                if (done) first = n;
            end else if (low_at == 0) begin
                if (!done) low_at = n;
            end else if (done) begin
                second = n;
                req = 1'b0;
            end
        end
        req = 1'b0;
        check("held first done", 32'(first), 32'd75);
        check("held done drop", 32'(low_at), 32'd76);
        check("held second done", 32'(second), 32'd151);
        check_cws("run4");
        check("run4 writes", 32'(wr_count - w0), 32'(4 * N));
        check("run4 oob", 32'(oob_count - o0), 32'd0);
        repeat (3) @(negedge clk);
        check("held no rerun", 32'(done), 32'h1);

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
